prog_sequence_counter: RTL

PROG_SEQUENCE_COUNTER -- requirements
Module: prog_sequence_counter

---
 rtl/prog_sequence_counter.sv | 119 +++++++++++
 1 files changed

// File: rtl/prog_sequence_counter.sv
// Programmable sequence counter: steps an index through a writable table and outputs the entry it lands on.
// Latency: 1 cycle from en or start sampled high to the new index/counter value; wrap, done and busy are registered.
// No backpressure: a step happens on every enabled cycle in RUN; start always wins over en.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   start                     : begin a new pass at index 0 (forward) or len_m1 (reverse)
//   en, dir, oneshot          : step enable, direction (1 = reverse), stop-at-end mode
//   len_m1                    : last active table index
//   wr_en, wr_addr, wr_data   : table write port, usable in every state
//   counter, index            : registered current table value and table index
//   wrap                      : one-cycle pulse on a wrapping end-of-pass step
//   done, busy                : state flags for DONE and RUN
module prog_sequence_counter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int STEP  = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             dir,
    input  logic             oneshot,
    input  logic [AW-1:0]    len_m1,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] counter,
    output logic [AW-1:0]    index,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   table_q [DEPTH];
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic [AW-1:0]      index_q, index_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               load;

    // Next-state logic. counter reloads only when the index is (re)targeted,
    // so a table write to the current entry stays invisible until revisited.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        wrap_d  = 1'b0;
        load    = 1'b0;

        if (start) begin
            index_d = dir ? len_m1 : '0;
            load    = 1'b1;
            state_d = RUN;
        end else if (state_q == RUN && en) begin
            // Forward end test uses >= so shrinking len_m1 below the current
            // index terminates the pass on the next step.
            if (!dir && index_q < len_m1) begin
                index_d = index_q + 1'b1;
                load    = 1'b1;
            end else if (dir && index_q != '0) begin
                index_d = index_q - 1'b1;
                load    = 1'b1;
            end else if (oneshot) begin
                state_d = DONE;
            end else begin
                index_d = dir ? len_m1 : '0;
                load    = 1'b1;
                wrap_d  = 1'b1;
            end
        end

        // Table read uses the pre-edge contents, so a same-cycle write to the
        // target entry is not seen by this load.
        counter_d = load ? table_q[index_d] : counter_q;
        done_d    = (state_d == DONE);
        busy_d    = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            index_q   <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= WIDTH'(i * STEP);
            end
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            index_q   <= index_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            if (wr_en) begin
                table_q[wr_addr] <= wr_data;
            end
        end
    end

    assign counter = counter_q;
    assign index   = index_q;
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule
